router_pkt_receiver: RTL and testbench

ROUTER_PKT_RECEIVER -- requirements
Module: router_pkt_receiver

---
 rtl/router_pkt_receiver.sv | 149 ++++++++++++++
 tb/tb_router_pkt_receiver.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_receiver.sv
// Output-port packet receiver: pulls one header/payload/parity packet from a FIFO,
// streams the payload to the sink, and reports parity/address status or a starvation abort.
module router_pkt_receiver #(
    parameter logic [1:0] PORT_ADDR = 2'b00,
    parameter int         TIMEOUT   = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       empty,
    input  logic [7:0] fifo_data,
    input  logic       sink_ready,
    output logic       read_enb,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic [5:0] pkt_len,
    output logic [1:0] pkt_addr,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       addr_err,
    output logic       pkt_abort,
    output logic       busy,
    output logic [1:0] dbg_state
);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        BODY     = 2'd2
    } state_t;

    state_t        state_q;
    logic [6:0]    issue_left_q, issue_left_d;
    logic [6:0]    recv_left_q, recv_left_d;
    logic [7:0]    acc_q, acc_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rd_vld_q;
    logic [5:0]    pkt_len_q;
    logic [1:0]    pkt_addr_q;
    logic          parity_err_q, addr_err_q;

    logic in_body, timed_out, last_byte, payload_byte, fire;

    // Handshake: a read fires in any cycle read_enb=1; its byte appears on
    // fifo_data the following cycle (tracked by rd_vld_q). out_valid is a
    // one-cycle pulse with no back-pressure; sink_ready only throttles reads.
    assign in_body      = (state_q == BODY);
    assign timed_out    = in_body && (starve_q == SW'(TIMEOUT)) && !reset;
    assign last_byte    = in_body && rd_vld_q && (recv_left_q == 7'd1) && !timed_out && !reset;
    assign payload_byte = in_body && rd_vld_q && (recv_left_q > 7'd1) && !timed_out && !reset;
    assign fire         = !reset && !empty &&
                          ((state_q == IDLE) ||
                           (in_body && (issue_left_q != 7'd0) && sink_ready && !timed_out));

    assign read_enb   = fire;
    assign out_valid  = payload_byte;
    assign out_data   = payload_byte ? fifo_data : 8'h00;
    assign pkt_done   = last_byte;
    assign pkt_abort  = timed_out;
    assign parity_err = last_byte ? (acc_q != fifo_data)      : (timed_out ? 1'b0 : parity_err_q);
    assign addr_err   = last_byte ? (pkt_addr_q != PORT_ADDR) : (timed_out ? 1'b0 : addr_err_q);
    assign pkt_len    = pkt_len_q;
    assign pkt_addr   = pkt_addr_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

    always_comb begin
        issue_left_d = issue_left_q;
        recv_left_d  = recv_left_q;
        acc_d        = acc_q;
        starve_d     = '0;
        case (state_q)
            HDR_WAIT: begin
                // Length field plus the trailing parity byte; 7 bits so 63+1 never wraps.
                issue_left_d = {1'b0, fifo_data[7:2]} + 7'd1;
                recv_left_d  = {1'b0, fifo_data[7:2]} + 7'd1;
                acc_d        = fifo_data;
            end
            BODY: begin
                if (fire) begin
                    issue_left_d = issue_left_q - 7'd1;
                end
                if (payload_byte) begin
                    acc_d       = acc_q ^ fifo_data;
                    recv_left_d = recv_left_q - 7'd1;
                end
                if (fire) begin
                    starve_d = '0;
                end else if ((issue_left_q != 7'd0) && empty && (starve_q != SW'(TIMEOUT))) begin
                    starve_d = starve_q + SW'(1);
                end else begin
                    starve_d = starve_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            issue_left_q <= '0;
            recv_left_q  <= '0;
            acc_q        <= '0;
            starve_q     <= '0;
            rd_vld_q     <= 1'b0;
            pkt_len_q    <= '0;
            pkt_addr_q   <= '0;
            parity_err_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            issue_left_q <= issue_left_d;
            recv_left_q  <= recv_left_d;
            acc_q        <= acc_d;
            starve_q     <= starve_d;
            rd_vld_q     <= in_body && fire;
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        state_q <= HDR_WAIT;
                    end
                end
                HDR_WAIT: begin
                    pkt_len_q  <= fifo_data[7:2];
                    pkt_addr_q <= fifo_data[1:0];
                    state_q    <= BODY;
                end
                BODY: begin
                    if (timed_out) begin
                        // Partial packet is dropped; stale status must not outlive it.
                        state_q      <= IDLE;
                        parity_err_q <= 1'b0;
                        addr_err_q   <= 1'b0;
                        starve_q     <= '0;
                        issue_left_q <= '0;
                        recv_left_q  <= '0;
                    end else if (last_byte) begin
                        state_q      <= IDLE;
                        parity_err_q <= (acc_q != fifo_data);
                        addr_err_q   <= (pkt_addr_q != PORT_ADDR);
                        starve_q     <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_receiver.sv
// Bench for router_pkt_receiver: a queue-based FIFO feeds two instances (port 01 and 00);
// a packet-level model predicts payload bytes and done status, plus directed timing checks.
module tb_router_pkt_receiver;
  localparam logic [1:0] PA0 = 2'b01;
  localparam logic [1:0] PA1 = 2'b00;
  localparam int         TMO = 30;

  logic       clock = 1'b0;
  logic       reset, empty, sink_ready;
  logic [7:0] fifo_data;

  logic       read_enb   [2];
  logic [7:0] out_data   [2];
  logic       out_valid  [2];
  logic [5:0] pkt_len    [2];
  logic [1:0] pkt_addr   [2];
  logic       pkt_done   [2];
  logic       parity_err [2];
  logic       addr_err   [2];
  logic       pkt_abort  [2];
  logic       busy       [2];
  logic [1:0] dbg_state  [2];

  router_pkt_receiver #(.PORT_ADDR(PA0), .TIMEOUT(TMO)) u_dut0 (
    .clock(clock), .reset(reset), .empty(empty), .fifo_data(fifo_data), .sink_ready(sink_ready),
    .read_enb(read_enb[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .pkt_len(pkt_len[0]), .pkt_addr(pkt_addr[0]), .pkt_done(pkt_done[0]),
    .parity_err(parity_err[0]), .addr_err(addr_err[0]), .pkt_abort(pkt_abort[0]),
    .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  router_pkt_receiver #(.PORT_ADDR(PA1), .TIMEOUT(TMO)) u_dut1 (
    .clock(clock), .reset(reset), .empty(empty), .fifo_data(fifo_data), .sink_ready(sink_ready),
    .read_enb(read_enb[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .pkt_len(pkt_len[1]), .pkt_addr(pkt_addr[1]), .pkt_done(pkt_done[1]),
    .parity_err(parity_err[1]), .addr_err(addr_err[1]), .pkt_abort(pkt_abort[1]),
    .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] pa_of(input int k);
    return (k == 0) ? PA0 : PA1;
  endfunction

  // FIFO contents and packet-level expectations
  logic [7:0] fifo_q     [$];
  logic [7:0] exp_q      [$];
  logic       exp_pe_q   [$];
  logic [5:0] exp_len_q  [$];
  logic [1:0] exp_addr_q [$];

  int idx [2] = '{0, 0};
  int didx[2] = '{0, 0};
  int n_valid[2] = '{0, 0};
  int n_done [2] = '{0, 0};
  int n_abort[2] = '{0, 0};
  int t_rd = 0, t_done = 0, t_prev_done = 0, t_abort = 0, t_last_valid = 0;
  int mark_id = 0, seen_mark = 0;

  // scoreboard: compares every out_valid / pkt_done against the model queues
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (read_enb[k]) check("rd_guard", {30'd0, empty, reset}, 32'd0);
      if (out_valid[k]) begin
        n_valid[k]++;
        if (idx[k] < exp_q.size()) begin
          check("payload", 32'(out_data[k]), 32'(exp_q[idx[k]]));
          idx[k]++;
        end else begin
          check("spurious_valid", 32'(out_valid[k]), 32'd0);
        end
      end
      if (pkt_done[k]) begin
        n_done[k]++;
        if (didx[k] < exp_pe_q.size()) begin
          check("done_parity_err", 32'(parity_err[k]), 32'(exp_pe_q[didx[k]]));
          check("done_addr_err", 32'(addr_err[k]), 32'(exp_addr_q[didx[k]] != pa_of(k)));
          check("done_pkt_len", 32'(pkt_len[k]), 32'(exp_len_q[didx[k]]));
          check("done_pkt_addr", 32'(pkt_addr[k]), 32'(exp_addr_q[didx[k]]));
          didx[k]++;
        end else begin
          check("spurious_done", 32'(pkt_done[k]), 32'd0);
        end
      end
      if (pkt_abort[k]) n_abort[k]++;
    end
    if (pkt_done[0]) begin
      t_prev_done = t_done;
      t_done      = cyc;
    end
    if (pkt_abort[0]) t_abort = cyc;
    if (out_valid[0]) t_last_valid = cyc;
    if (read_enb[0] && (seen_mark != mark_id)) begin
      t_rd      = cyc;
      seen_mark = mark_id;
    end
  end

  // driver tasks
  logic fire;

  task automatic step();
    @(negedge clock);
    fire = read_enb[0];
    @(posedge clock);
    #1;
    if (fire && (fifo_q.size() > 0)) fifo_data = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
  endtask

  task automatic send_pkt(input int len, input logic [1:0] addr, input logic [7:0] flip, input int keep);
    logic [7:0] hdr, acc, b;
    hdr = {len[5:0], addr};
    acc = hdr;
    fifo_q.push_back(hdr);
    for (int i = 0; i < len; i++) begin
      b   = 8'($urandom_range(0, 255));
      acc = acc ^ b;
      if (i < keep) begin
        fifo_q.push_back(b);
        exp_q.push_back(b);
      end
    end
    if (keep >= len) begin
      fifo_q.push_back(acc ^ flip);
      exp_pe_q.push_back(flip != 8'h00);
      exp_len_q.push_back(len[5:0]);
      exp_addr_q.push_back(addr);
    end
    mark_id++;
    empty = (fifo_q.size() == 0);
  endtask

  task automatic wait_done(input int target, input string name);
    int b;
    b = 0;
    while ((n_done[0] < target) && (b < 200)) begin
      step();
      b++;
    end
    check(name, 32'(n_done[0] >= target), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    #3;
    for (int k = 0; k < 2; k++) begin
      check({tag, "_read_enb"},   32'(read_enb[k]),   32'd0);
      check({tag, "_out_data"},   32'(out_data[k]),   32'd0);
      check({tag, "_out_valid"},  32'(out_valid[k]),  32'd0);
      check({tag, "_pkt_len"},    32'(pkt_len[k]),    32'd0);
      check({tag, "_pkt_addr"},   32'(pkt_addr[k]),   32'd0);
      check({tag, "_pkt_done"},   32'(pkt_done[k]),   32'd0);
      check({tag, "_parity_err"}, 32'(parity_err[k]), 32'd0);
      check({tag, "_addr_err"},   32'(addr_err[k]),   32'd0);
      check({tag, "_pkt_abort"},  32'(pkt_abort[k]),  32'd0);
      check({tag, "_busy"},       32'(busy[k]),       32'd0);
    end
  endtask

  initial begin
    int nv, nd, na, na1, b;
    reset      = 1'b1;
    empty      = 1'b1;
    sink_ready = 1'b1;
    fifo_data  = 8'h00;
    repeat (3) step();
    check_zero("reset");
    reset = 1'b0;
    step();

    // len 12 addr 01, good parity
    nv = n_valid[0];
    send_pkt(12, 2'b01, 8'h00, 12);
    wait_done(1, "p12_done_timeout");
    #3;
    check("p12_latency", 32'(t_done - t_rd), 32'd15);
    check("p12_valid_count", 32'(n_valid[0] - nv), 32'd12);
    check("p12_last_valid", 32'(t_done - t_last_valid), 32'd1);
    check("p12_pkt_len", 32'(pkt_len[0]), 32'd12);
    check("p12_pkt_addr", 32'(pkt_addr[0]), 32'd1);
    check("p12_parity_err", 32'(parity_err[0]), 32'd0);
    check("p12_addr_err0", 32'(addr_err[0]), 32'd0);
    check("p12_addr_err1", 32'(addr_err[1]), 32'd1);

    // len 7 with sink_ready low for 10 cycles after 3 payload reads
    step();
    nv = n_valid[0];
    send_pkt(7, 2'b01, 8'h00, 7);
    repeat (5) step();
    sink_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #3;
      check("stall_read_enb", 32'(read_enb[0]), 32'd0);
      check("stall_abort", 32'(pkt_abort[0]), 32'd0);
      step();
    end
    sink_ready = 1'b1;
    check("stall_valids_before", 32'(n_valid[0] - nv), 32'd3);
    wait_done(2, "p7_done_timeout");
    check("p7_latency", 32'(t_done - t_rd), 32'd20);
    check("p7_valid_count", 32'(n_valid[0] - nv), 32'd7);
    check("p7_no_abort", 32'(n_abort[0]), 32'd0);

    // len 12 with corrupted parity
    step();
    send_pkt(12, 2'b01, 8'h01, 12);
    wait_done(3, "bad_parity_timeout");
    #3;
    check("bad_parity_err0", 32'(parity_err[0]), 32'd1);
    check("bad_parity_err1", 32'(parity_err[1]), 32'd1);

    // len 5 starved after 2 payload bytes
    step();
    nv = n_valid[0]; nd = n_done[0]; na = n_abort[0]; na1 = n_abort[1];
    send_pkt(5, 2'b01, 8'h00, 2);
    b = 0;
    while ((n_abort[0] == na) && (b < 80)) begin
      step();
      b++;
    end
    check("abort_seen", 32'(n_abort[0] - na), 32'd1);
    check("abort_latency", 32'(t_abort - t_rd), 32'd34);
    check("abort_valids", 32'(n_valid[0] - nv), 32'd2);
    check("abort_no_done", 32'(n_done[0] - nd), 32'd0);
    #3;
    check("abort_busy0", 32'(busy[0]), 32'd0);
    check("abort_busy1", 32'(busy[1]), 32'd0);
    check("abort_parity_cleared", 32'(parity_err[0]), 32'd0);
    check("abort_addr_cleared", 32'(addr_err[1]), 32'd0);
    check("abort_seen1", 32'(n_abort[1] - na1), 32'd1);

    // hand-built len 1 packet: header 05, payload A5, parity 05^A5 = A0
    step();
    fifo_q.push_back(8'h05);
    fifo_q.push_back(8'hA5);
    fifo_q.push_back(8'hA0);
    exp_q.push_back(8'hA5);
    exp_pe_q.push_back(1'b0);
    exp_len_q.push_back(6'd1);
    exp_addr_q.push_back(2'b01);
    mark_id++;
    empty = 1'b0;
    wait_done(4, "p1_done_timeout");
    #3;
    check("p1_latency", 32'(t_done - t_rd), 32'd4);
    check("p1_parity_err", 32'(parity_err[0]), 32'd0);

    // reset in the middle of a len 20 body
    step();
    nv = n_valid[0]; nd = n_done[0]; na = n_abort[0];
    send_pkt(20, 2'b01, 8'h00, 20);
    repeat (6) step();
    reset = 1'b1;
    #3;
    check("rst_cycle_read_enb", 32'(read_enb[0]), 32'd0);
    check("rst_cycle_out_valid", 32'(out_valid[0]), 32'd0);
    step();
    reset = 1'b0;
    fifo_q.delete();
    while (exp_q.size() > idx[0]) void'(exp_q.pop_back());
    while (exp_pe_q.size() > didx[0]) begin
      void'(exp_pe_q.pop_back());
      void'(exp_len_q.pop_back());
      void'(exp_addr_q.pop_back());
    end
    empty = 1'b1;
    check_zero("midrst");
    repeat (5) step();
    check("midrst_no_done", 32'(n_done[0] - nd), 32'd0);
    check("midrst_no_abort", 32'(n_abort[0] - na), 32'd0);
    check("midrst_valids", 32'(n_valid[0] - nv), 32'd3);

    // back-to-back: len 0 addr 00, then len 63 addr 10
    step();
    nv = n_valid[0]; nd = n_done[0];
    send_pkt(0, 2'b00, 8'h00, 0);
    send_pkt(63, 2'b10, 8'h00, 63);
    wait_done(nd + 2, "b2b_done_timeout");
    #3;
    check("b2b_first_latency", 32'(t_prev_done - t_rd), 32'd3);
    check("b2b_gap", 32'(t_done - t_prev_done), 32'd67);
    check("b2b_valids", 32'(n_valid[0] - nv), 32'd63);
    check("b2b_addr_err1", 32'(addr_err[1]), 32'd1);
    check("b2b_pkt_len", 32'(pkt_len[1]), 32'd63);

    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      check("payload_all_seen", 32'(idx[k]), 32'(exp_q.size()));
      check("done_all_seen", 32'(didx[k]), 32'(exp_pe_q.size()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
